sub_div_combine_seq: RTL and testbench

//  Inverse companion of the combinational 4-bit add/mul block: given a product, a sum and operand b,

---
 rtl/sub_div_combine_seq_if.sv | 25 ++
 rtl/sub_div_combine_seq.sv | 128 ++++++++++++
 tb/tb_sub_div_combine_seq.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sub_div_combine_seq_if.sv
// Job/result handshake bundle for the sequential divide/subtract block.
interface sub_div_combine_seq_if #(parameter int W = 4);
  logic           in_valid;
  logic           in_ready;
  logic [2*W-1:0] prod;
  logic [W-1:0]   sum;
  logic [W-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   Result_quo;
  logic [W-1:0]   Result_rem;
  logic [W-1:0]   Result_sub;
  logic           div_zero;
  logic           ovf;

  modport master (
    output in_valid, prod, sum, b, out_ready,
    input  in_ready, out_valid, Result_quo, Result_rem, Result_sub, div_zero, ovf
  );

  modport slave (
    input  in_valid, prod, sum, b, out_ready,
    output in_ready, out_valid, Result_quo, Result_rem, Result_sub, div_zero, ovf
  );
endinterface

// File: rtl/sub_div_combine_seq.sv
// Recovers operand a from a product (restoring division by b, one bit per clock)
// and from a sum (modular subtraction of b).
//
//  state  | meaning
//  S_IDLE | waiting for a job; in_ready high
//  S_CALC | shifting out one quotient bit per clock
//  S_DONE | results valid; held until out_ready
module sub_div_combine_seq #(
  parameter int W = 4
) (
  input logic                      clk,
  input logic                      rst,
  sub_div_combine_seq_if.slave     bus
);

  localparam int CW = $clog2(W) + 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t         r_state;
  state_t         w_state_nxt;

  logic [W-1:0]   r_b;
  logic [W-1:0]   r_r;
  logic [W-1:0]   r_q;
  logic [CW-1:0]  r_cnt;
  logic [W-1:0]   r_quo;
  logic [W-1:0]   r_rem;
  logic [W-1:0]   r_sub;
  logic           r_dz;
  logic           r_ovf;

  logic           w_accept;
  logic           w_b_zero;
  logic           w_q_ovf;
  logic           w_last;
  logic [W:0]     w_shift;
  logic [W:0]     w_diff;
  logic           w_ge;
  logic [W-1:0]   w_r_nxt;
  logic [W-1:0]   w_q_nxt;

  assign w_accept = bus.in_valid && (r_state == S_IDLE);
  assign w_b_zero = (bus.b == '0);
  assign w_q_ovf  = (bus.prod[2*W-1:W] >= bus.b);
  assign w_last   = (r_cnt == CW'(W - 1));

  // R < b holds between steps, so only the shifted value needs the extra bit.
  assign w_shift  = {r_r, r_q[W-1]};
  assign w_diff   = w_shift - {1'b0, r_b};
  assign w_ge     = (w_shift >= {1'b0, r_b});
  assign w_r_nxt  = w_ge ? w_diff[W-1:0] : w_shift[W-1:0];
  assign w_q_nxt  = {r_q[W-2:0], w_ge};

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = (w_b_zero || w_q_ovf) ? S_DONE : S_CALC;
      S_CALC: if (w_last) w_state_nxt = S_DONE;
      S_DONE: if (bus.out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_b   <= '0;
      r_r   <= '0;
      r_q   <= '0;
      r_cnt <= '0;
      r_quo <= '0;
      r_rem <= '0;
      r_sub <= '0;
      r_dz  <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_b   <= bus.b;
            r_sub <= bus.sum - bus.b;
            if (w_b_zero) begin
              r_dz  <= 1'b1;
              r_ovf <= 1'b0;
              r_quo <= '1;
              r_rem <= bus.prod[W-1:0];
            end else if (w_q_ovf) begin
              r_dz  <= 1'b0;
              r_ovf <= 1'b1;
              r_quo <= '1;
              r_rem <= '0;
            end else begin
              r_dz  <= 1'b0;
              r_ovf <= 1'b0;
              r_r   <= bus.prod[2*W-1:W];
              r_q   <= bus.prod[W-1:0];
              r_cnt <= '0;
            end
          end
        end
        S_CALC: begin
          r_r   <= w_r_nxt;
          r_q   <= w_q_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_quo <= w_q_nxt;
            r_rem <= w_r_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready   = (r_state == S_IDLE);
  assign bus.out_valid  = (r_state == S_DONE);
  assign bus.Result_quo = r_quo;
  assign bus.Result_rem = r_rem;
  assign bus.Result_sub = r_sub;
  assign bus.div_zero   = r_dz;
  assign bus.ovf        = r_ovf;

endmodule

// File: tb/tb_sub_div_combine_seq.sv
// Directed bench for sub_div_combine_seq: hand-computed vectors, identity sweep,
// backpressure, reset abort and input-ignore scenarios.
module tb_sub_div_combine_seq;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  sub_div_combine_seq_if #(.W(4)) bus ();

  sub_div_combine_seq #(.W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Offers one job, waits for the result, captures it and pops it.
  task automatic run_job(input logic [7:0] p, input logic [3:0] s, input logic [3:0] bb,
                         output logic [3:0] q, output logic [3:0] r, output logic [3:0] d,
                         output logic dz, output logic ov, output int lat);
    int guard = 0;
    bus.prod = p; bus.sum = s; bus.b = bb; bus.in_valid = 1'b1;
    while (!bus.in_ready && guard < 20) begin @(posedge clk); #1; guard++; end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    q = bus.Result_quo; r = bus.Result_rem; d = bus.Result_sub;
    dz = bus.div_zero; ov = bus.ovf;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.prod = '0; bus.sum = '0; bus.b = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.Result_quo !== 4'd0 ||
        bus.Result_rem !== 4'd0 || bus.Result_sub !== 4'd0 || bus.div_zero !== 1'b0 || bus.ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: rdy=%b vld=%b q=%0d r=%0d s=%0d dz=%b ov=%b, want rdy=1 vld=0 rest 0",
               bus.in_ready, bus.out_valid, bus.Result_quo, bus.Result_rem, bus.Result_sub, bus.div_zero, bus.ovf);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [3:0] q, r, d; logic dz, ov; int lat;
    run_job(8'h8F, 4'd8, 4'd13, q, r, d, dz, ov, lat);
    n_checks++;
    if (lat !== 5) begin n_fail++; $display("FAIL basic_latency: got %0d want 5", lat); end
    n_checks++;
    if (q !== 4'd11 || r !== 4'd0) begin n_fail++; $display("FAIL basic_div: got q=%0d r=%0d want q=11 r=0", q, r); end
    n_checks++;
    if (d !== 4'd11) begin n_fail++; $display("FAIL basic_sub: got %0d want 11", d); end
    n_checks++;
    if (dz !== 1'b0 || ov !== 1'b0) begin n_fail++; $display("FAIL basic_flags: got dz=%b ov=%b want 0 0", dz, ov); end
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_pop: got rdy=%b vld=%b want 1 0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_directed();
    logic [3:0] q, r, d; logic dz, ov; int lat;
    run_job(8'd100, 4'd3, 4'd7, q, r, d, dz, ov, lat);
    n_checks++;
    if (lat !== 5 || q !== 4'd14 || r !== 4'd2 || d !== 4'd12 || dz !== 1'b0 || ov !== 1'b0) begin
      n_fail++;
      $display("FAIL directed_100_7: got lat=%0d q=%0d r=%0d s=%0d dz=%b ov=%b want 5 14 2 12 0 0", lat, q, r, d, dz, ov);
    end
    // hi nibble one below b: largest quotient that still fits
    run_job(8'h2F, 4'd5, 4'd3, q, r, d, dz, ov, lat);
    n_checks++;
    if (lat !== 5 || q !== 4'd15 || r !== 4'd2 || d !== 4'd2 || ov !== 1'b0) begin
      n_fail++;
      $display("FAIL directed_47_3: got lat=%0d q=%0d r=%0d s=%0d ov=%b want 5 15 2 2 0", lat, q, r, d, ov);
    end
  endtask

  task automatic test_identity();
    logic [3:0] q, r, d; logic dz, ov; int lat;
    logic [7:0] p; logic [3:0] s;
    for (int a = 1; a < 16; a++) begin
      for (int bb = 1; bb < 16; bb++) begin
        p = 8'(a * bb);
        s = 4'((a + bb) % 16);
        run_job(p, s, 4'(bb), q, r, d, dz, ov, lat);
        n_checks++;
        if (lat !== 5 || q !== 4'(a) || r !== 4'd0 || d !== 4'(a) || dz !== 1'b0 || ov !== 1'b0) begin
          n_fail++;
          $display("FAIL identity a=%0d b=%0d: got lat=%0d q=%0d r=%0d s=%0d dz=%b ov=%b want lat=5 q=%0d r=0 s=%0d 0 0",
                   a, bb, lat, q, r, d, dz, ov, a, a);
        end
      end
    end
  endtask

  task automatic test_div_zero();
    logic [3:0] q, r, d; logic dz, ov; int lat;
    run_job(8'h35, 4'd9, 4'd0, q, r, d, dz, ov, lat);
    n_checks++;
    if (lat !== 1) begin n_fail++; $display("FAIL divzero_latency: got %0d want 1", lat); end
    n_checks++;
    if (dz !== 1'b1 || ov !== 1'b0 || q !== 4'hF || r !== 4'd5 || d !== 4'd9) begin
      n_fail++;
      $display("FAIL divzero_results: got dz=%b ov=%b q=%0h r=%0d s=%0d want 1 0 f 5 9", dz, ov, q, r, d);
    end
  endtask

  task automatic test_ovf();
    logic [3:0] q, r, d; logic dz, ov; int lat;
    run_job(8'hF0, 4'd0, 4'd3, q, r, d, dz, ov, lat);
    n_checks++;
    if (lat !== 1 || ov !== 1'b1 || dz !== 1'b0 || q !== 4'hF || r !== 4'd0 || d !== 4'd13) begin
      n_fail++;
      $display("FAIL ovf_f0_3: got lat=%0d ov=%b dz=%b q=%0h r=%0d s=%0d want 1 1 0 f 0 13", lat, ov, dz, q, r, d);
    end
    // hi nibble equal to b is already an overflow
    run_job(8'h30, 4'd4, 4'd3, q, r, d, dz, ov, lat);
    n_checks++;
    if (lat !== 1 || ov !== 1'b1 || q !== 4'hF || r !== 4'd0 || d !== 4'd1) begin
      n_fail++;
      $display("FAIL ovf_equal: got lat=%0d ov=%b q=%0h r=%0d s=%0d want 1 1 f 0 1", lat, ov, q, r, d);
    end
  endtask

  task automatic test_backpressure();
    int guard;
    bus.prod = 8'd100; bus.sum = 4'd3; bus.b = 4'd7; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    guard = 0;
    while (!bus.out_valid && guard < 40) begin @(posedge clk); #1; guard++; end
    n_checks++;
    if (!bus.out_valid) begin n_fail++; $display("FAIL bp_timeout: out_valid=%b want 1", bus.out_valid); end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.Result_quo !== 4'd14 ||
          bus.Result_rem !== 4'd2 || bus.Result_sub !== 4'd12) begin
        n_fail++;
        $display("FAIL bp_hold cycle %0d: got vld=%b rdy=%b q=%0d r=%0d s=%0d want 1 0 14 2 12",
                 i, bus.out_valid, bus.in_ready, bus.Result_quo, bus.Result_rem, bus.Result_sub);
      end
    end
    bus.out_ready = 1'b1;
    bus.prod = 8'h8F; bus.sum = 4'd8; bus.b = 4'd13; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release: got vld=%b rdy=%b want 0 1", bus.out_valid, bus.in_ready);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_accept: got rdy=%b want 0", bus.in_ready); end
    guard = 1;
    while (!bus.out_valid && guard < 40) begin @(posedge clk); #1; guard++; end
    n_checks++;
    if (guard !== 5 || bus.Result_quo !== 4'd11 || bus.Result_rem !== 4'd0 || bus.Result_sub !== 4'd11) begin
      n_fail++;
      $display("FAIL b2b_result: got lat=%0d q=%0d r=%0d s=%0d want 5 11 0 11",
               guard, bus.Result_quo, bus.Result_rem, bus.Result_sub);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_calc();
    logic [3:0] q, r, d; logic dz, ov; int lat;
    bus.prod = 8'd100; bus.sum = 4'd3; bus.b = 4'd7; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.Result_quo !== 4'd0 ||
        bus.Result_rem !== 4'd0 || bus.Result_sub !== 4'd0 || bus.div_zero !== 1'b0 || bus.ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_calc: got rdy=%b vld=%b q=%0d r=%0d s=%0d dz=%b ov=%b want 1 0 0 0 0 0 0",
               bus.in_ready, bus.out_valid, bus.Result_quo, bus.Result_rem, bus.Result_sub, bus.div_zero, bus.ovf);
    end
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_discard cycle %0d: got vld=%b want 0", i, bus.out_valid); end
    end
    run_job(8'h8F, 4'd8, 4'd13, q, r, d, dz, ov, lat);
    n_checks++;
    if (lat !== 5 || q !== 4'd11 || r !== 4'd0 || d !== 4'd11 || dz !== 1'b0 || ov !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_recover: got lat=%0d q=%0d r=%0d s=%0d dz=%b ov=%b want 5 11 0 11 0 0", lat, q, r, d, dz, ov);
    end
  endtask

  task automatic test_ignore_inputs();
    int guard;
    bus.prod = 8'h8F; bus.sum = 4'd8; bus.b = 4'd13; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    bus.prod = 8'h20; bus.sum = 4'd1; bus.b = 4'd2; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    guard = 0;
    while (!bus.out_valid && guard < 40) begin @(posedge clk); #1; guard++; end
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.Result_quo !== 4'd11 || bus.Result_rem !== 4'd0 ||
        bus.Result_sub !== 4'd11 || bus.div_zero !== 1'b0 || bus.ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_result: got vld=%b q=%0d r=%0d s=%0d dz=%b ov=%b want 1 11 0 11 0 0",
               bus.out_valid, bus.Result_quo, bus.Result_rem, bus.Result_sub, bus.div_zero, bus.ovf);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL ignore_no_queue: got rdy=%b vld=%b want 1 0", bus.in_ready, bus.out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_directed();
    test_identity();
    test_div_zero();
    test_ovf();
    test_backpressure();
    test_reset_mid_calc();
    test_ignore_inputs();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
